if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset (word-aligned).
REQ-002 Parameter CNT_W, default 16, meaning width of the stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 PC_IFWrite  input  1  from hazard detector; 1 = PC and IF/ID update; 0 = both hold.
REQ-006 BranchTaken_id  input  1  branch in ID resolved taken.
REQ-007 BranchAddr_id  input  32  branch target.
REQ-008 Jump_id  input  1  jump in ID.
REQ-009 JumpAddr_id  input  32  jump target.
REQ-010 IMemData  input  32  instruction at IMemAddr; combinational read, same cycle.
REQ-011 IMemAddr  output  32  fetch address; equals PC_if.
REQ-012 PC_if  output  32  current PC register.
REQ-013 Instr_id  output  32  IF/ID instruction register.
REQ-014 PCPlus4_id  output  32  IF/ID copy of fetch PC + 4.
REQ-015 Valid_id  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 StallCount  output  CNT_W  count of cycles with PC_IFWrite = 0.

Function
REQ-017 Next PC selection, priority: Jump_id -> JumpAddr_id; else BranchTaken_id -> BranchAddr_id; else PC_if + 4.
REQ-018 Redirect targets have bits [1:0] forced to 2'b00 before loading PC.
REQ-019 PC_if + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-020 PC_IFWrite = 1, no redirect: PC <= PC_if + 4; Instr_id <= IMemData; PCPlus4_id <= PC_if + 4; Valid_id <= 1.
REQ-021 PC_IFWrite = 1, redirect (Jump_id or BranchTaken_id): PC <= target; Instr_id <= NOP (32'h0000_0000); PCPlus4_id <= 32'h0; Valid_id <= 0 (one-cycle flush).
REQ-022 PC_IFWrite = 0: PC, Instr_id, PCPlus4_id, Valid_id all hold; Jump_id/BranchTaken_id ignored that cycle (ID re-presents them after stall).
REQ-023 Simultaneous Jump_id and BranchTaken_id: jump wins; single flush.
REQ-024 StallCount increments by 1 each cycle PC_IFWrite = 0; saturates at all-ones; never wraps.
REQ-025 Latency: instruction at PC_if appears on Instr_id one clock later when PC_IFWrite = 1.
REQ-026 Redirect penalty exactly one bubble; target instruction reaches Instr_id two clocks after redirect cycle.

Reset
REQ-027 rst_n low asynchronously sets PC_if = RESET_PC, Instr_id = NOP, PCPlus4_id = 0, Valid_id = 0, StallCount = 0.
REQ-028 Reset asserted mid-stall or mid-redirect discards pending redirect; first fetch after release is RESET_PC.
REQ-029 First rising edge after rst_n release performs a normal REQ-020 update.

Structure
REQ-030 Shared package mips_pkg holds NOP encoding, data width 32, default RESET_PC.
REQ-031 One sub-module pc_reg: PC register with async reset, write enable, next-PC mux; if_stage instantiates it and owns IF/ID register and counter.

Verification
REQ-032 Reset release, PC_IFWrite = 1, IMem returns 32'h2001_0005 at 0 -> cycle 1: PC_if = 4, Instr_id = 32'h2001_0005, PCPlus4_id = 4, Valid_id = 1.
REQ-033 PC_IFWrite = 0 for 3 cycles at PC_if = 8 -> PC_if stays 8, IF/ID unchanged, StallCount = 3; next enabled cycle PC_if = 12.
REQ-034 BranchTaken_id = 1, BranchAddr_id = 32'h40 -> next cycle PC_if = 32'h40, Instr_id = 0, Valid_id = 0; cycle after Valid_id = 1 with IMem[32'h40].
REQ-035 Jump_id = 1 (32'h100) and BranchTaken_id = 1 (32'h40) same cycle -> PC_if = 32'h100, one bubble.
REQ-036 BranchTaken_id = 1 (target 32'h43) while PC_IFWrite = 0 -> no redirect; when PC_IFWrite = 1 next cycle -> PC_if = 32'h40.
REQ-037 PC_if = 32'hFFFF_FFFC, no redirect -> PC_if = 0, PCPlus4_id = 0; force StallCount to 16'hFFFE, stall 3 cycles -> holds 16'hFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: data width, NOP encoding,
// default reset vector and the next-PC source selector.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } pc_sel_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus between the fetch stage and its neighbours: hazard/ID control, the
// instruction memory port, and the IF/ID register outputs.
interface if_stage_if #(
    parameter int CNT_W = 16
) ();
    // PC_IFWrite is a plain enable: 1 = PC and IF/ID advance this edge,
    // 0 = both hold and any redirect request in the same cycle is ignored.
    // IMemData must be a combinational function of IMemAddr.
    logic             PC_IFWrite;
    logic             BranchTaken_id;
    logic [31:0]      BranchAddr_id;
    logic             Jump_id;
    logic [31:0]      JumpAddr_id;
    logic [31:0]      IMemData;
    logic [31:0]      IMemAddr;
    logic [31:0]      PC_if;
    logic [31:0]      Instr_id;
    logic [31:0]      PCPlus4_id;
    logic             Valid_id;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output PC_IFWrite, BranchTaken_id, BranchAddr_id, Jump_id, JumpAddr_id,
        output IMemData,
        input  IMemAddr, PC_if, Instr_id, PCPlus4_id, Valid_id, StallCount
    );

    modport slave (
        input  PC_IFWrite, BranchTaken_id, BranchAddr_id, Jump_id, JumpAddr_id,
        input  IMemData,
        output IMemAddr, PC_if, Instr_id, PCPlus4_id, Valid_id, StallCount
    );
endinterface

// File: rtl/pc_reg.sv
// Program counter: next-PC selection (jump > branch > sequential) and the
// PC register itself with write enable and asynchronous reset.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    input  logic        branch,
    input  logic [31:0] branch_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect
);

    pc_sel_e     sel;
    logic [31:0] pc_next;

    // Sequential increment wraps naturally at 2^32.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        sel = SEL_SEQ;
        if (jump) begin
            sel = SEL_JUMP;
        end else if (branch) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            SEL_JUMP:   pc_next = word_align(jump_addr);
            SEL_BRANCH: pc_next = word_align(branch_addr);
            default:    pc_next = pc_plus4;
        endcase
    end

    assign redirect = (sel != SEL_SEQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (we) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the IF/ID pipeline register and the stall
// counter; the PC and its next-address mux live in pc_reg.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input logic       clk,
    input logic       rst_n,
    if_stage_if.slave bus
);

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             redirect;
    logic [31:0]      instr_q;
    logic [31:0]      pcp4_q;
    logic             valid_q;
    logic [CNT_W-1:0] stall_cnt;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (bus.PC_IFWrite),
        .jump        (bus.Jump_id),
        .jump_addr   (bus.JumpAddr_id),
        .branch      (bus.BranchTaken_id),
        .branch_addr (bus.BranchAddr_id),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .redirect    (redirect)
    );

    // A redirect squashes the wrong-path fetch into a single bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.PC_IFWrite) begin
            if (redirect) begin
                instr_q <= NOP;
                pcp4_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                instr_q <= bus.IMemData;
                pcp4_q  <= pc_plus4;
                valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!bus.PC_IFWrite && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.IMemAddr   = pc;
    assign bus.PC_if      = pc;
    assign bus.Instr_id   = instr_q;
    assign bus.PCPlus4_id = pcp4_q;
    assign bus.Valid_id   = valid_q;
    assign bus.StallCount = stall_cnt;

endmodule
